// File: rtl/arbiter_out4.sv
// arbiter_out4: round-robin wormhole arbiter for router output port 4.
// Five input ports compete for output 4. The grant is one-hot and registered.
// Once an input wins, it keeps the output until its tail flit transfers.
// After each release, the priority pointer moves to the input just past the
// releasing owner, which keeps the arbitration fair.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no owner; grant4 = 0; arbitrate among req starting at ptr
// LOCKED | owner_q holds output 4 until its tail flit transfers
module arbiter_out4 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       req,
  input  logic [4:0]       tail,
  input  logic             out_ready,
  output logic [4:0]       grant4,
  output logic             busy,
  output logic             xfer,
  output logic [CNT_W-1:0] pkt_cnt
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_q;
  logic [2:0]       ptr_q;
  logic [2:0]       owner_q;
  logic [4:0]       grant_q;
  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;

  logic             pick_valid;
  logic [2:0]       pick_idx;
  logic [2:0]       scan_idx;
  logic [4:0]       grant_d;
  logic [2:0]       ptr_d;
  logic [CNT_W-1:0] cnt_d;
  logic             tail_xfer;

  // Modulo-5 reduction for sums in 0..9. The pointer and owner are always
  // kept in 0..4, so their sums stay in that range.
  function automatic logic [2:0] wrap5(input logic [3:0] v);
    logic [3:0] r;
    r = (v >= 4'd5) ? (v - 4'd5) : v;
    return r[2:0];
  endfunction

  // Round-robin pick: scan ptr, ptr+1, ..., ptr+4 (mod 5).
  // The scan runs backwards so that the closest requester, assigned last, wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 3'd0;
    scan_idx   = 3'd0;
    for (int off = 4; off >= 0; off--) begin
      scan_idx = wrap5({1'b0, ptr_q} + 4'(off));
      if (req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  // Next-value helpers for the grant, the pointer after release, and the counter.
  always_comb begin
    grant_d = 5'b00001 << pick_idx;
    ptr_d   = wrap5({1'b0, owner_q} + 4'd1);
    cnt_d   = cnt_q + 1'b1;
  end

  // A flit moves when the current owner presents one and downstream has credit.
  // The grant is one-hot, so masking by it selects the owner's req and tail bits.
  always_comb begin
    xfer      = (|(grant_q & req)) & out_ready;
    tail_xfer = (|(grant_q & req & tail)) & out_ready;
  end

  // Arbitration / ownership FSM with registered outputs.
  // Reset takes priority over any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      owner_q <= 3'd0;
      grant_q <= 5'b00000;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= grant_d;
            owner_q <= pick_idx;
            busy_q  <= 1'b1;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          // Stalls, bubbles and non-tail flits all keep the current owner.
          if (tail_xfer) begin
            grant_q <= 5'b00000;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            state_q <= IDLE;
          end
        end
        default: begin
          grant_q <= 5'b00000;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant4  = grant_q;
  assign busy    = busy_q;
  assign pkt_cnt = cnt_q;

endmodule

// File: tb/tb_arbiter_out4.sv
// Testbench for arbiter_out4.
// Two instances share all inputs: one with the default 8-bit counter and one
// with a 2-bit counter, so the same stimulus also exercises counter wrap.
module tb_arbiter_out4;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       out_ready;

  logic [4:0] grant_a, grant_b;
  logic       busy_a, busy_b;
  logic       xfer_a, xfer_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int n_vec = 0;
  int n_err = 0;

  arbiter_out4 dut_a (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .out_ready(out_ready),
    .grant4(grant_a), .busy(busy_a), .xfer(xfer_a), .pkt_cnt(cnt_a)
  );

  arbiter_out4 #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .req(req), .tail(tail), .out_ready(out_ready),
    .grant4(grant_b), .busy(busy_b), .xfer(xfer_b), .pkt_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each row holds the inputs for one cycle, the expected xfer during that
  // cycle (x = don't check), and the expected registered state after the edge.
  typedef struct {
    logic       r;
    logic [4:0] rq;
    logic [4:0] tl;
    logic       rdy;
    logic       x;
    logic [4:0] g;
    logic       b;
    int         cnt;
  } vec_t;

  typedef struct {
    logic [4:0] g;
    logic       b;
    int         cnt;
  } exp_t;

  exp_t sb[$];

  function automatic vec_t v(logic r, logic [4:0] rq, logic [4:0] tl, logic rdy,
                             logic x, logic [4:0] g, logic b, int cnt);
    vec_t t;
    t.r = r; t.rq = rq; t.tl = tl; t.rdy = rdy;
    t.x = x; t.g = g; t.b = b; t.cnt = cnt;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rst       = t.r;
    req       = t.rq;
    tail      = t.tl;
    out_ready = t.rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t tv[$];
    exp_t e;
    tv.push_back(v(1, 5'b11111, 5'b00000, 1, 1'bx, 5'b00000, 0, 0));
    tv.push_back(v(1, 5'b11111, 5'b00000, 1, 1'b0, 5'b00000, 0, 0));
    tv.push_back(v(0, 5'b00000, 5'b00000, 1, 1'b0, 5'b00000, 0, 0));
    tv.push_back(v(0, 5'b00000, 5'b00000, 1, 1'b0, 5'b00000, 0, 0));
    foreach (tv[i]) begin
      drive(tv[i]);
      #1;
      if (tv[i].x !== 1'bx) begin
        n_vec++;
        if (xfer_a !== tv[i].x || xfer_b !== tv[i].x) begin
          n_err++;
          $display("FAIL reset xfer row %0d: got %b/%b want %b", i, xfer_a, xfer_b, tv[i].x);
        end
      end
      sb.push_back('{tv[i].g, tv[i].b, tv[i].cnt});
      tick();
      e = sb.pop_front();
      n_vec++;
      if (grant_a !== e.g || grant_b !== e.g || busy_a !== e.b || busy_b !== e.b ||
          cnt_a !== 8'(e.cnt) || cnt_b !== 2'(e.cnt)) begin
        n_err++;
        $display("FAIL reset state row %0d: got g=%b/%b b=%b/%b c=%0d/%0d want g=%b b=%b c=%0d",
                 i, grant_a, grant_b, busy_a, busy_b, cnt_a, cnt_b, e.g, e.b, e.cnt);
      end
    end
  endtask

  task automatic test_rotation();
    vec_t tv[$];
    exp_t e;
    tv.push_back(v(1, 5'b00000, 5'b00000, 1, 1'bx, 5'b00000, 0, 0));
    tv.push_back(v(0, 5'b11111, 5'b11111, 1, 1'b0, 5'b00001, 1, 0));
    tv.push_back(v(0, 5'b11111, 5'b11111, 1, 1'b1, 5'b00000, 0, 1));
    tv.push_back(v(0, 5'b11111, 5'b11111, 1, 1'b0, 5'b00010, 1, 1));
    tv.push_back(v(0, 5'b11111, 5'b11111, 1, 1'b1, 5'b00000, 0, 2));
    tv.push_back(v(0, 5'b11111, 5'b11111, 1, 1'b0, 5'b00100, 1, 2));
    tv.push_back(v(0, 5'b11111, 5'b11111, 1, 1'b1, 5'b00000, 0, 3));
    tv.push_back(v(0, 5'b11111, 5'b11111, 1, 1'b0, 5'b01000, 1, 3));
    tv.push_back(v(0, 5'b11111, 5'b11111, 1, 1'b1, 5'b00000, 0, 4));
    tv.push_back(v(0, 5'b11111, 5'b11111, 1, 1'b0, 5'b10000, 1, 4));
    tv.push_back(v(0, 5'b11111, 5'b11111, 1, 1'b1, 5'b00000, 0, 5));
    tv.push_back(v(0, 5'b11111, 5'b11111, 1, 1'b0, 5'b00001, 1, 5));
    foreach (tv[i]) begin
      drive(tv[i]);
      #1;
      if (tv[i].x !== 1'bx) begin
        n_vec++;
        if (xfer_a !== tv[i].x || xfer_b !== tv[i].x) begin
          n_err++;
          $display("FAIL rotation xfer row %0d: got %b/%b want %b", i, xfer_a, xfer_b, tv[i].x);
        end
      end
      sb.push_back('{tv[i].g, tv[i].b, tv[i].cnt});
      tick();
      e = sb.pop_front();
      n_vec++;
      if (grant_a !== e.g || grant_b !== e.g || busy_a !== e.b || busy_b !== e.b ||
          cnt_a !== 8'(e.cnt) || cnt_b !== 2'(e.cnt)) begin
        n_err++;
        $display("FAIL rotation state row %0d: got g=%b/%b b=%b/%b c=%0d/%0d want g=%b b=%b c=%0d",
                 i, grant_a, grant_b, busy_a, busy_b, cnt_a, cnt_b, e.g, e.b, e.cnt);
      end
    end
  endtask

  task automatic test_wormhole();
    vec_t tv[$];
    exp_t e;
    tv.push_back(v(1, 5'b00000, 5'b00000, 1, 1'bx, 5'b00000, 0, 0));
    tv.push_back(v(0, 5'b00100, 5'b00000, 0, 1'b0, 5'b00100, 1, 0));
    tv.push_back(v(0, 5'b00101, 5'b00001, 1, 1'b1, 5'b00100, 1, 0));
    tv.push_back(v(0, 5'b00101, 5'b00001, 1, 1'b1, 5'b00100, 1, 0));
    tv.push_back(v(0, 5'b00101, 5'b00001, 0, 1'b0, 5'b00100, 1, 0));
    tv.push_back(v(0, 5'b00101, 5'b00001, 0, 1'b0, 5'b00100, 1, 0));
    tv.push_back(v(0, 5'b00101, 5'b00001, 0, 1'b0, 5'b00100, 1, 0));
    tv.push_back(v(0, 5'b00101, 5'b00001, 1, 1'b1, 5'b00100, 1, 0));
    tv.push_back(v(0, 5'b00101, 5'b00101, 1, 1'b1, 5'b00000, 0, 1));
    tv.push_back(v(0, 5'b00001, 5'b00001, 1, 1'b0, 5'b00001, 1, 1));
    tv.push_back(v(0, 5'b00001, 5'b00001, 1, 1'b1, 5'b00000, 0, 2));
    foreach (tv[i]) begin
      drive(tv[i]);
      #1;
      if (tv[i].x !== 1'bx) begin
        n_vec++;
        if (xfer_a !== tv[i].x || xfer_b !== tv[i].x) begin
          n_err++;
          $display("FAIL wormhole xfer row %0d: got %b/%b want %b", i, xfer_a, xfer_b, tv[i].x);
        end
      end
      sb.push_back('{tv[i].g, tv[i].b, tv[i].cnt});
      tick();
      e = sb.pop_front();
      n_vec++;
      if (grant_a !== e.g || grant_b !== e.g || busy_a !== e.b || busy_b !== e.b ||
          cnt_a !== 8'(e.cnt) || cnt_b !== 2'(e.cnt)) begin
        n_err++;
        $display("FAIL wormhole state row %0d: got g=%b/%b b=%b/%b c=%0d/%0d want g=%b b=%b c=%0d",
                 i, grant_a, grant_b, busy_a, busy_b, cnt_a, cnt_b, e.g, e.b, e.cnt);
      end
    end
  endtask

  task automatic test_bubble();
    vec_t tv[$];
    exp_t e;
    tv.push_back(v(1, 5'b00000, 5'b00000, 1, 1'bx, 5'b00000, 0, 0));
    tv.push_back(v(0, 5'b01000, 5'b00000, 1, 1'b0, 5'b01000, 1, 0));
    tv.push_back(v(0, 5'b01010, 5'b00000, 1, 1'b1, 5'b01000, 1, 0));
    tv.push_back(v(0, 5'b00010, 5'b00010, 1, 1'b0, 5'b01000, 1, 0));
    tv.push_back(v(0, 5'b00010, 5'b00010, 1, 1'b0, 5'b01000, 1, 0));
    tv.push_back(v(0, 5'b01010, 5'b01000, 1, 1'b1, 5'b00000, 0, 1));
    tv.push_back(v(0, 5'b00010, 5'b00000, 1, 1'b0, 5'b00010, 1, 1));
    tv.push_back(v(0, 5'b00010, 5'b00010, 1, 1'b1, 5'b00000, 0, 2));
    foreach (tv[i]) begin
      drive(tv[i]);
      #1;
      if (tv[i].x !== 1'bx) begin
        n_vec++;
        if (xfer_a !== tv[i].x || xfer_b !== tv[i].x) begin
          n_err++;
          $display("FAIL bubble xfer row %0d: got %b/%b want %b", i, xfer_a, xfer_b, tv[i].x);
        end
      end
      sb.push_back('{tv[i].g, tv[i].b, tv[i].cnt});
      tick();
      e = sb.pop_front();
      n_vec++;
      if (grant_a !== e.g || grant_b !== e.g || busy_a !== e.b || busy_b !== e.b ||
          cnt_a !== 8'(e.cnt) || cnt_b !== 2'(e.cnt)) begin
        n_err++;
        $display("FAIL bubble state row %0d: got g=%b/%b b=%b/%b c=%0d/%0d want g=%b b=%b c=%0d",
                 i, grant_a, grant_b, busy_a, busy_b, cnt_a, cnt_b, e.g, e.b, e.cnt);
      end
    end
  endtask

  task automatic test_tail_gated();
    vec_t tv[$];
    exp_t e;
    tv.push_back(v(1, 5'b00000, 5'b00000, 1, 1'bx, 5'b00000, 0, 0));
    tv.push_back(v(0, 5'b00010, 5'b00010, 0, 1'b0, 5'b00010, 1, 0));
    tv.push_back(v(0, 5'b00010, 5'b00010, 0, 1'b0, 5'b00010, 1, 0));
    tv.push_back(v(0, 5'b00010, 5'b00010, 0, 1'b0, 5'b00010, 1, 0));
    tv.push_back(v(0, 5'b00010, 5'b00010, 1, 1'b1, 5'b00000, 0, 1));
    tv.push_back(v(0, 5'b00000, 5'b00000, 1, 1'b0, 5'b00000, 0, 1));
    tv.push_back(v(0, 5'b00000, 5'b00000, 1, 1'b0, 5'b00000, 0, 1));
    foreach (tv[i]) begin
      drive(tv[i]);
      #1;
      if (tv[i].x !== 1'bx) begin
        n_vec++;
        if (xfer_a !== tv[i].x || xfer_b !== tv[i].x) begin
          n_err++;
          $display("FAIL tail_gated xfer row %0d: got %b/%b want %b", i, xfer_a, xfer_b, tv[i].x);
        end
      end
      sb.push_back('{tv[i].g, tv[i].b, tv[i].cnt});
      tick();
      e = sb.pop_front();
      n_vec++;
      if (grant_a !== e.g || grant_b !== e.g || busy_a !== e.b || busy_b !== e.b ||
          cnt_a !== 8'(e.cnt) || cnt_b !== 2'(e.cnt)) begin
        n_err++;
        $display("FAIL tail_gated state row %0d: got g=%b/%b b=%b/%b c=%0d/%0d want g=%b b=%b c=%0d",
                 i, grant_a, grant_b, busy_a, busy_b, cnt_a, cnt_b, e.g, e.b, e.cnt);
      end
    end
  endtask

  task automatic test_wrap_reset();
    vec_t tv[$];
    exp_t e;
    tv.push_back(v(1, 5'b00000, 5'b00000, 1, 1'bx, 5'b00000, 0, 0));
    for (int k = 1; k <= 4; k++) begin
      tv.push_back(v(0, 5'b00001, 5'b00001, 1, 1'b0, 5'b00001, 1, k - 1));
      tv.push_back(v(0, 5'b00001, 5'b00001, 1, 1'b1, 5'b00000, 0, k));
    end
    tv.push_back(v(0, 5'b00001, 5'b00000, 1, 1'b0, 5'b00001, 1, 4));
    tv.push_back(v(0, 5'b00001, 5'b00000, 1, 1'b1, 5'b00001, 1, 4));
    tv.push_back(v(1, 5'b00001, 5'b00001, 1, 1'b1, 5'b00000, 0, 0));
    tv.push_back(v(0, 5'b00000, 5'b00000, 1, 1'b0, 5'b00000, 0, 0));
    foreach (tv[i]) begin
      drive(tv[i]);
      #1;
      if (tv[i].x !== 1'bx) begin
        n_vec++;
        if (xfer_a !== tv[i].x || xfer_b !== tv[i].x) begin
          n_err++;
          $display("FAIL wrap_reset xfer row %0d: got %b/%b want %b", i, xfer_a, xfer_b, tv[i].x);
        end
      end
      sb.push_back('{tv[i].g, tv[i].b, tv[i].cnt});
      tick();
      e = sb.pop_front();
      n_vec++;
      if (grant_a !== e.g || grant_b !== e.g || busy_a !== e.b || busy_b !== e.b ||
          cnt_a !== 8'(e.cnt) || cnt_b !== 2'(e.cnt)) begin
        n_err++;
        $display("FAIL wrap_reset state row %0d: got g=%b/%b b=%b/%b c=%0d/%0d want g=%b b=%b c=%0d",
                 i, grant_a, grant_b, busy_a, busy_b, cnt_a, cnt_b, e.g, e.b, e.cnt);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    req       = 5'b00000;
    tail      = 5'b00000;
    out_ready = 1'b0;
    test_reset();
    test_rotation();
    test_wormhole();
    test_bubble();
    test_tail_gated();
    test_wrap_reset();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got no summary, want summary");
    $fatal(1);
  end

endmodule
